// File: rtl/floor_scroller_if.sv
// Bus bundle for floor_scroller: pixel coordinates, scroll control, pit table
// writes, ground query and the registered results; clock and reset stay separate.
interface floor_scroller_if #(
    parameter int WORLD_W   = 13,
    parameter int TILE_LOG2 = 4,
    parameter int STEP_W    = 4
);
    logic [9:0]           DrawX;
    logic [9:0]           DrawY;
    logic                 frame_start;
    logic                 scroll_req;
    logic [STEP_W-1:0]    scroll_step;
    logic                 pit_we;
    logic [1:0]           pit_idx;
    logic [WORLD_W-1:0]   pit_start;
    logic [WORLD_W-1:0]   pit_end;
    logic [WORLD_W-1:0]   query_x;
    logic [WORLD_W-1:0]   cam_x;
    logic                 is_floor;
    logic [TILE_LOG2-1:0] tile_u;
    logic [TILE_LOG2-1:0] tile_v;
    logic                 query_solid;

    modport master (
        output DrawX, DrawY, frame_start, scroll_req, scroll_step,
               pit_we, pit_idx, pit_start, pit_end, query_x,
        input  cam_x, is_floor, tile_u, tile_v, query_solid
    );

    modport slave (
        input  DrawX, DrawY, frame_start, scroll_req, scroll_step,
               pit_we, pit_idx, pit_start, pit_end, query_x,
        output cam_x, is_floor, tile_u, tile_v, query_solid
    );
endinterface

// File: rtl/floor_scroller.sv
// Scrolling world-space ground strip with a programmable pit table.
// Define FLOOR_WRAP_EN to make the camera, pixel world X and query X wrap modulo WORLD_LEN.
module floor_scroller #(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int FLOOR_TOP = 448,
    parameter int TILE_LOG2 = 4,
    parameter int WORLD_W   = 13,
    parameter int WORLD_LEN = 3392,
    parameter int NUM_PITS  = 3,
    parameter int STEP_W    = 4
) (
    input logic            Clk,
    input logic            Reset_n,
    floor_scroller_if.slave bus
);
    // Two spare bits so sums and the doubled level length never overflow.
    localparam int XW = WORLD_W + 2;
    typedef logic [WORLD_W-1:0] wx_t;
    typedef logic [XW-1:0]      ext_t;

    localparam ext_t WLEN_X  = ext_t'(WORLD_LEN);
    localparam ext_t MAXCAM_X = ext_t'(WORLD_LEN - SCREEN_W);
`ifdef FLOOR_WRAP_EN
    localparam ext_t WLEN2_X  = ext_t'(2 * WORLD_LEN);
    localparam ext_t PENDMAX_X = ext_t'(WORLD_LEN - 1);
`else
    localparam ext_t PENDMAX_X = ext_t'(WORLD_LEN - SCREEN_W);
`endif
    localparam logic [9:0]           SCREEN_W_L  = 10'(SCREEN_W);
    localparam logic [9:0]           SCREEN_H_L  = 10'(SCREEN_H);
    localparam logic [9:0]           FLOOR_TOP_L = 10'(FLOOR_TOP);
    localparam logic [TILE_LOG2-1:0] FT_LO       = TILE_LOG2'(FLOOR_TOP);

    wx_t                  cam_x_q, cam_x_d;
    wx_t                  pending_q, pending_d;
    wx_t                  pit_start_q [NUM_PITS];
    wx_t                  pit_start_d [NUM_PITS];
    wx_t                  pit_end_q   [NUM_PITS];
    wx_t                  pit_end_d   [NUM_PITS];
    logic [NUM_PITS-1:0]  pit_en_q, pit_en_d;
    wx_t                  wx_q, wx_d;
    logic                 band_q, band_d;
    logic [TILE_LOG2-1:0] dy_q, dy_d;
    logic                 is_floor_q, is_floor_d;
    logic [TILE_LOG2-1:0] tile_u_q, tile_u_d;
    logic [TILE_LOG2-1:0] tile_v_q, tile_v_d;
    logic                 query_solid_q, query_solid_d;

    ext_t pend_base, pend_sum, cam_sum, px_sum, qx;

    // Half-open test against every enabled pit.
    function automatic logic in_pit(input wx_t x);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_PITS; i++)
            hit |= pit_en_q[i] && (x >= pit_start_q[i]) && (x < pit_end_q[i]);
        return hit;
    endfunction

    // Camera: steps accumulate in pending and only land on cam_x at frame_start.
    always_comb begin
        pend_base = bus.frame_start ? '0 : ext_t'(pending_q);
        pend_sum  = pend_base + ext_t'(bus.scroll_step);
        pending_d = wx_t'(pend_base);
        if (bus.scroll_req)
            pending_d = (pend_sum > PENDMAX_X) ? wx_t'(PENDMAX_X) : wx_t'(pend_sum);

        cam_sum = ext_t'(cam_x_q) + ext_t'(pending_q);
        cam_x_d = cam_x_q;
        if (bus.frame_start) begin
`ifdef FLOOR_WRAP_EN
            cam_x_d = (cam_sum >= WLEN_X) ? wx_t'(cam_sum - WLEN_X) : wx_t'(cam_sum);
`else
            cam_x_d = (cam_sum > MAXCAM_X) ? wx_t'(MAXCAM_X) : wx_t'(cam_sum);
`endif
        end
    end

    always_comb begin
        pit_start_d = pit_start_q;
        pit_end_d   = pit_end_q;
        pit_en_d    = pit_en_q;
        if (bus.pit_we && (int'(bus.pit_idx) < NUM_PITS)) begin
            pit_start_d[bus.pit_idx] = bus.pit_start;
            pit_end_d[bus.pit_idx]   = bus.pit_end;
            pit_en_d[bus.pit_idx]    = bus.pit_start < bus.pit_end;
        end
    end

    // Stage 1: world X, band membership and tile row.
    always_comb begin
        px_sum = ext_t'(cam_x_q) + ext_t'(bus.DrawX);
`ifdef FLOOR_WRAP_EN
        if (px_sum >= WLEN_X)
            px_sum = px_sum - WLEN_X;
`endif
        wx_d   = wx_t'(px_sum);
        band_d = (bus.DrawX < SCREEN_W_L) && (bus.DrawY >= FLOOR_TOP_L) && (bus.DrawY < SCREEN_H_L);
        dy_d   = bus.DrawY[TILE_LOG2-1:0] - FT_LO;
    end

    // Stage 2 plus the camera-independent ground query.
    always_comb begin
        is_floor_d = band_q && !in_pit(wx_q);
        tile_u_d   = is_floor_d ? wx_q[TILE_LOG2-1:0] : '0;
        tile_v_d   = is_floor_d ? dy_q : '0;

        qx = ext_t'(bus.query_x);
`ifdef FLOOR_WRAP_EN
        // Two conditional subtractions cover any query_x below 3*WORLD_LEN.
        if (qx >= WLEN2_X)
            qx = qx - WLEN2_X;
        else if (qx >= WLEN_X)
            qx = qx - WLEN_X;
        query_solid_d = !in_pit(wx_t'(qx));
`else
        query_solid_d = (qx < WLEN_X) && !in_pit(bus.query_x);
`endif
    end

    // NOTE: state uses non-blocking assignments; the small pit table is reset
    // like any other register because a stale enabled entry would punch a hole.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cam_x_q       <= '0;
            pending_q     <= '0;
            pit_en_q      <= '0;
            for (int i = 0; i < NUM_PITS; i++) begin
                pit_start_q[i] <= '0;
                pit_end_q[i]   <= '0;
            end
            wx_q          <= '0;
            band_q        <= 1'b0;
            dy_q          <= '0;
            is_floor_q    <= 1'b0;
            tile_u_q      <= '0;
            tile_v_q      <= '0;
            query_solid_q <= 1'b0;
        end else begin
            cam_x_q       <= cam_x_d;
            pending_q     <= pending_d;
            pit_en_q      <= pit_en_d;
            pit_start_q   <= pit_start_d;
            pit_end_q     <= pit_end_d;
            wx_q          <= wx_d;
            band_q        <= band_d;
            dy_q          <= dy_d;
            is_floor_q    <= is_floor_d;
            tile_u_q      <= tile_u_d;
            tile_v_q      <= tile_v_d;
            query_solid_q <= query_solid_d;
        end
    end

    assign bus.cam_x       = cam_x_q;
    assign bus.is_floor    = is_floor_q;
    assign bus.tile_u      = tile_u_q;
    assign bus.tile_v      = tile_v_q;
    assign bus.query_solid = query_solid_q;
endmodule

// File: tb/tb_floor_scroller.sv
// Self-checking bench for floor_scroller: pixel vector table plus directed
// sequences for scrolling, clamp/wrap, pit writes, query and reset.
module tb_floor_scroller;
    logic Clk;
    logic Reset_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    floor_scroller_if bus ();

    floor_scroller dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       f;
        logic [3:0] u;
        logic [3:0] v;
        string      name;
    } pix_vec_t;

    pix_vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pixel(input logic [9:0] x, input logic [9:0] y, input logic f,
                         input logic [3:0] u, input logic [3:0] v, input string name);
        bus.DrawX = x;
        bus.DrawY = y;
        tick();
        tick();
        check({name, ".is_floor"}, bus.is_floor, f);
        check({name, ".tile_u"}, bus.tile_u, u);
        check({name, ".tile_v"}, bus.tile_v, v);
    endtask

    task automatic write_pit(input logic [1:0] idx, input logic [12:0] s, input logic [12:0] e);
        bus.pit_idx   = idx;
        bus.pit_start = s;
        bus.pit_end   = e;
        bus.pit_we    = 1'b1;
        tick();
        bus.pit_we    = 1'b0;
    endtask

    task automatic scroll(input logic [3:0] step, input int cycles);
        bus.scroll_step = step;
        bus.scroll_req  = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        bus.scroll_req  = 1'b0;
    endtask

    task automatic frame(input logic [12:0] exp_cam, input string name);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        check(name, bus.cam_x, exp_cam);
    endtask

    task automatic query(input logic [12:0] qx, input logic exp, input string name);
        bus.query_x = qx;
        tick();
        check(name, bus.query_solid, exp);
    endtask

    initial begin
        Reset_n         = 1'b0;
        bus.DrawX       = '0;
        bus.DrawY       = '0;
        bus.frame_start = 1'b0;
        bus.scroll_req  = 1'b0;
        bus.scroll_step = '0;
        bus.pit_we      = 1'b0;
        bus.pit_idx     = '0;
        bus.pit_start   = '0;
        bus.pit_end     = '0;
        bus.query_x     = '0;

        vecs[0]  = '{10'd5,   10'd447, 1'b0, 4'd0,  4'd0,  "above_band"};
        vecs[1]  = '{10'd5,   10'd448, 1'b1, 4'd5,  4'd0,  "band_top"};
        vecs[2]  = '{10'd5,   10'd479, 1'b1, 4'd5,  4'd15, "band_bottom"};
        vecs[3]  = '{10'd0,   10'd480, 1'b0, 4'd0,  4'd0,  "below_band"};
        vecs[4]  = '{10'd99,  10'd460, 1'b1, 4'd3,  4'd12, "pit_left_edge"};
        vecs[5]  = '{10'd100, 10'd460, 1'b0, 4'd0,  4'd0,  "pit_start"};
        vecs[6]  = '{10'd131, 10'd460, 1'b0, 4'd0,  4'd0,  "pit_last"};
        vecs[7]  = '{10'd132, 10'd460, 1'b1, 4'd4,  4'd12, "pit_end"};
        vecs[8]  = '{10'd639, 10'd479, 1'b1, 4'd15, 4'd15, "right_edge"};
        vecs[9]  = '{10'd640, 10'd479, 1'b0, 4'd0,  4'd0,  "past_width"};
        vecs[10] = '{10'd1023,10'd460, 1'b0, 4'd0,  4'd0,  "blank_x"};

        // Reset state, checked while reset is held.
        tick();
        tick();
        check("rst.cam_x", bus.cam_x, 0);
        check("rst.is_floor", bus.is_floor, 0);
        check("rst.tile_u", bus.tile_u, 0);
        check("rst.tile_v", bus.tile_v, 0);
        check("rst.query_solid", bus.query_solid, 0);
        Reset_n = 1'b1;

        write_pit(2'd0, 13'd100, 13'd132);
        foreach (vecs[i])
            pixel(vecs[i].x, vecs[i].y, vecs[i].f, vecs[i].u, vecs[i].v, vecs[i].name);

        // Full-throughput sweep across the pit's left edge.
        bus.DrawY = 10'd460;
        for (int i = 0; i < 12; i++) begin
            bus.DrawX = 10'(94 + i);
            tick();
            if (i >= 1) begin
                int  px;
                logic ef;
                px = 94 + i - 1;
                ef = !(px >= 100 && px < 132);
                check($sformatf("stream_x%0d.is_floor", px), bus.is_floor, ef);
                check($sformatf("stream_x%0d.tile_u", px), bus.tile_u, ef ? (px % 16) : 0);
            end
        end

        query(13'd120, 1'b0, "query_in_pit");
        query(13'd99,  1'b1, "query_before_pit");
        query(13'd132, 1'b1, "query_pit_end");
`ifdef FLOOR_WRAP_EN
        query(13'd3400, 1'b1, "query_past_level");
`else
        query(13'd3400, 1'b0, "query_past_level");
`endif

        // Accumulated steps land only at frame_start.
        scroll(4'd8, 3);
        check("scroll.cam_before_frame", bus.cam_x, 0);
        frame(13'd24, "scroll.cam_after_frame");
        pixel(10'd76, 10'd460, 1'b0, 4'd0, 4'd0, "cam24_x76");
        pixel(10'd75, 10'd460, 1'b1, 4'd3, 4'd12, "cam24_x75");

        // Coincident step seeds the next frame's pending.
        bus.scroll_step = 4'd8;
        bus.scroll_req  = 1'b1;
        bus.frame_start = 1'b1;
        tick();
        bus.scroll_req  = 1'b0;
        bus.frame_start = 1'b0;
        check("coincide.cam_unchanged", bus.cam_x, 24);
        tick();
        check("coincide.cam_midframe", bus.cam_x, 24);
        frame(13'd32, "coincide.cam_next_frame");

        // Large request: saturate pending, then clamp (or wrap) on commit.
        scroll(4'd15, 270);
`ifdef FLOOR_WRAP_EN
        frame(13'd31, "sat.cam_commit");
        pixel(10'd639, 10'd460, 1'b1, 4'd14, 4'd12, "sat.x639");
        scroll(4'd15, 1);
        frame(13'd46, "sat.cam_again");
        pixel(10'd5, 10'd460, 1'b1, 4'd3, 4'd12, "prerst.x5");
`else
        frame(13'd2752, "sat.cam_commit");
        pixel(10'd639, 10'd460, 1'b1, 4'd15, 4'd12, "sat.x639");
        scroll(4'd15, 1);
        frame(13'd2752, "sat.cam_again");
        pixel(10'd5, 10'd460, 1'b1, 4'd5, 4'd12, "prerst.x5");
`endif

        // Reset mid-line clears at once; output returns after two valid cycles.
        Reset_n = 1'b0;
        #1;
        check("midrst.is_floor", bus.is_floor, 0);
        check("midrst.tile_u", bus.tile_u, 0);
        check("midrst.cam_x", bus.cam_x, 0);
        #1;
        Reset_n = 1'b1;
        bus.DrawX = 10'd5;
        tick();
        check("postrst.cycle1_is_floor", bus.is_floor, 0);
        tick();
        check("postrst.cycle2_is_floor", bus.is_floor, 1);
        check("postrst.cycle2_tile_u", bus.tile_u, 5);

        // Pit table writes: disable by empty range, ignore out-of-range index.
        write_pit(2'd0, 13'd100, 13'd132);
        pixel(10'd120, 10'd460, 1'b0, 4'd0, 4'd0, "pits.p0_active");
        write_pit(2'd0, 13'd200, 13'd200);
        pixel(10'd120, 10'd460, 1'b1, 4'd8, 4'd12, "pits.p0_disabled");
        pixel(10'd200, 10'd460, 1'b1, 4'd8, 4'd12, "pits.empty_range");
        write_pit(2'd3, 13'd300, 13'd340);
        pixel(10'd310, 10'd460, 1'b1, 4'd6, 4'd12, "pits.idx3_ignored");
        write_pit(2'd2, 13'd300, 13'd340);
        pixel(10'd310, 10'd460, 1'b0, 4'd0, 4'd0, "pits.p2_inside");
        pixel(10'd340, 10'd460, 1'b1, 4'd4, 4'd12, "pits.p2_end");
        query(13'd339, 1'b0, "pits.query_last");

`ifdef FLOOR_WRAP_EN
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        scroll(4'd15, 225);
        scroll(4'd5, 1);
        frame(13'd3380, "wrap.cam_3380");
        pixel(10'd20, 10'd460, 1'b1, 4'd8, 4'd12, "wrap.pixel_loop");
        scroll(4'd15, 1);
        scroll(4'd5, 1);
        frame(13'd8, "wrap.cam_wrapped");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
